// File: rtl/bsg_down_rd_ctrl_if.sv
// Buffer read port plus core valid/ready word port of the downstream read controller.
interface bsg_down_rd_ctrl_if #(
  parameter int unsigned PTR_LG = 6
);
  logic [PTR_LG-1:0] buffer_addr1;
  logic              buffer_ren1;
  logic [15:0]       buffer_rdata1;
  logic [31:0]       core_data_out;
  logic              core_valid_out;
  logic              core_ready;

  modport master (
    output buffer_addr1, buffer_ren1, core_data_out, core_valid_out,
    input  buffer_rdata1, core_ready
  );

  modport slave (
    input  buffer_addr1, buffer_ren1, core_data_out, core_valid_out,
    output buffer_rdata1, core_ready
  );
endinterface

// File: rtl/bsg_down_rd_ctrl.sv
// Core-side read controller: pairs 16-bit buffer entries into 32-bit core words,
// advances the read pointer and returns credit tokens to the io side.
module bsg_down_rd_ctrl #(
  parameter int unsigned PTR_LG      = 6,
  parameter int unsigned TOKEN_WORDS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PTR_LG:0]   wptr,
  output logic [PTR_LG:0]   rptr,
  output logic              io_token_out,
  output logic [PTR_LG:0]   occupancy,
  output logic              ptr_err,
  bsg_down_rd_ctrl_if.master bus
);

  localparam int unsigned PW    = PTR_LG + 1;
  localparam int unsigned AW    = PTR_LG;
  localparam int unsigned CNT_W = (TOKEN_WORDS > 1) ? $clog2(TOKEN_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, LO, HI, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] credit;
  logic             avail;

  assign occupancy = wptr - rptr;
  assign avail     = (occupancy >= PW'(2));

  // Read port is driven straight from state so data lands exactly one cycle later.
  always_comb begin
    bus.buffer_ren1  = 1'b0;
    bus.buffer_addr1 = '0;
    case (state)
      IDLE: begin
        if (avail) begin
          bus.buffer_ren1  = 1'b1;
          bus.buffer_addr1 = rptr[AW-1:0];
        end
      end
      LO: begin
        bus.buffer_ren1  = 1'b1;
        bus.buffer_addr1 = rptr[AW-1:0] + AW'(1);
      end
      HOLD: begin
        if (bus.core_ready && avail) begin
          bus.buffer_ren1  = 1'b1;
          bus.buffer_addr1 = rptr[AW-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      rptr               <= '0;
      bus.core_data_out  <= '0;
      bus.core_valid_out <= 1'b0;
      io_token_out       <= 1'b0;
      credit             <= '0;
      ptr_err            <= 1'b0;
    end else begin
      io_token_out <= 1'b0;

      // Writer overran the reader; flagged only, no recovery.
      if (occupancy > PW'(1 << PTR_LG)) begin
        ptr_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (avail) begin
            state <= LO;
          end
        end
        LO: begin
          bus.core_data_out[15:0] <= bus.buffer_rdata1;
          state                   <= HI;
        end
        HI: begin
          bus.core_data_out[31:16] <= bus.buffer_rdata1;
          bus.core_valid_out       <= 1'b1;
          rptr                     <= rptr + PW'(2);
          state                    <= HOLD;
          // Entries are freed here, so credit is returned on the pointer advance.
          if (credit == CNT_W'(TOKEN_WORDS - 1)) begin
            credit       <= '0;
            io_token_out <= 1'b1;
          end else begin
            credit <= credit + CNT_W'(1);
          end
        end
        HOLD: begin
          if (bus.core_ready) begin
            bus.core_valid_out <= 1'b0;
            state              <= avail ? LO : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_down_rd_ctrl.sv
// Directed self-checking bench for bsg_down_rd_ctrl with a one-cycle-latency buffer model.
module tb_bsg_down_rd_ctrl;

  logic       clk;
  logic       rst;
  logic [6:0] wptr;
  logic [6:0] rptr;
  logic       io_token_out;
  logic [6:0] occupancy;
  logic       ptr_err;

  bsg_down_rd_ctrl_if #(.PTR_LG(6)) bus ();

  bsg_down_rd_ctrl #(.PTR_LG(6), .TOKEN_WORDS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .wptr         (wptr),
    .rptr         (rptr),
    .io_token_out (io_token_out),
    .occupancy    (occupancy),
    .ptr_err      (ptr_err),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:63];
  logic [5:0]  rd_log [0:1023];
  int          rd_n = 0;
  int          tok_pulses = 0;
  int          tok_long = 0;
  int          tok_misal = 0;
  logic        tok_prev = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Synchronous buffer: data is returned the cycle after the read enable.
  always @(posedge clk) begin
    if (bus.buffer_ren1) bus.buffer_rdata1 <= mem[bus.buffer_addr1];
  end

  always @(posedge clk) begin
    if (!rst && bus.buffer_ren1) begin
      rd_log[rd_n] = bus.buffer_addr1;
      rd_n = rd_n + 1;
    end
  end

  // Token pulses: one cycle wide, coincident with a fresh word at a 4-entry boundary.
  always @(negedge clk) begin
    if (io_token_out) begin
      if (tok_prev) tok_long = tok_long + 1;
      else          tok_pulses = tok_pulses + 1;
      if (!(bus.core_valid_out && rptr[1:0] == 2'd0)) tok_misal = tok_misal + 1;
    end
    tok_prev = io_token_out;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int base;
  int lat;
  int tok_base;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    rst = 1'b1;
    wptr = 7'd0;
    bus.core_ready = 1'b0;
    bus.buffer_rdata1 = 16'h0;

    // Reset then idle
    tick(); tick();
    check("rst_rptr", 32'(rptr), 32'd0);
    check("rst_valid", 32'(bus.core_valid_out), 32'd0);
    check("rst_data", bus.core_data_out, 32'd0);
    check("rst_token", 32'(io_token_out), 32'd0);
    check("rst_err", 32'(ptr_err), 32'd0);
    rst = 1'b0;
    tick(); tick();
    check("idle_ren", 32'(bus.buffer_ren1), 32'd0);
    check("idle_addr", 32'(bus.buffer_addr1), 32'd0);
    check("idle_reads", 32'(rd_n), 32'd0);
    check("idle_occ", 32'(occupancy), 32'd0);

    // Single word
    mem[0] = 16'h1111; mem[1] = 16'h2222;
    base = rd_n;
    wptr = 7'd2;
    lat = 0;
    while (!bus.core_valid_out && lat < 10) begin tick(); lat++; end
    check("single_latency", 32'(lat), 32'd3);
    check("single_data", bus.core_data_out, 32'h22221111);
    check("single_rptr", 32'(rptr), 32'd2);
    check("single_nreads", 32'(rd_n - base), 32'd2);
    check("single_addr0", 32'(rd_log[base]), 32'd0);
    check("single_addr1", 32'(rd_log[base+1]), 32'd1);
    bus.core_ready = 1'b1;
    tick();
    check("single_drop", 32'(bus.core_valid_out), 32'd0);
    bus.core_ready = 1'b0;

    // Backpressure then back-to-back
    for (int i = 2; i < 8; i++) mem[i] = 16'hA000 + 16'(i);
    base = rd_n;
    wptr = 7'd8;
    tick(); tick(); tick();
    check("bp_first_valid", 32'(bus.core_valid_out), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", bus.core_data_out, 32'hA003A002);
      check("bp_hold_valid", 32'(bus.core_valid_out), 32'd1);
    end
    check("bp_no_reads", 32'(rd_n - base), 32'd2);
    bus.core_ready = 1'b1;
    tick();
    check("b2b_gap1", 32'(bus.core_valid_out), 32'd0);
    tick();
    check("b2b_gap2", 32'(bus.core_valid_out), 32'd0);
    tick();
    check("b2b_w2_data", bus.core_data_out, 32'hA005A004);
    check("b2b_w2_rptr", 32'(rptr), 32'd6);
    tick(); tick(); tick();
    check("b2b_w3_data", bus.core_data_out, 32'hA007A006);
    check("b2b_w3_valid", 32'(bus.core_valid_out), 32'd1);
    check("b2b_rptr", 32'(rptr), 32'd8);
    tick();
    check("b2b_done", 32'(bus.core_valid_out), 32'd0);
    for (int k = 0; k < 6; k++) check("b2b_addr", 32'(rd_log[base+k]), 32'(k + 2));

    // Odd occupancy: the lone entry waits for its partner
    mem[8] = 16'hB008; mem[9] = 16'hB009; mem[10] = 16'hB00A; mem[11] = 16'hB00B;
    base = rd_n;
    wptr = 7'd11;
    tick(); tick(); tick();
    check("odd_data", bus.core_data_out, 32'hB009B008);
    check("odd_rptr", 32'(rptr), 32'd10);
    tick(); tick(); tick(); tick();
    check("odd_occ", 32'(occupancy), 32'd1);
    check("odd_ren", 32'(bus.buffer_ren1), 32'd0);
    check("odd_nreads", 32'(rd_n - base), 32'd2);
    wptr = 7'd12;
    tick(); tick(); tick();
    check("odd_pair_data", bus.core_data_out, 32'hB00BB00A);
    check("odd_pair_rptr", 32'(rptr), 32'd12);
    tick();

    // Preload to rptr=62, then wrap-around
    wptr = 7'd62;
    lat = 0;
    while (rptr != 7'd62 && lat < 300) begin tick(); lat++; end
    check("preload_rptr", 32'(rptr), 32'd62);
    tick();
    mem[62] = 16'hC03E; mem[63] = 16'hC03F; mem[0] = 16'hC000; mem[1] = 16'hC001;
    base = rd_n;
    wptr = 7'h42;
    tick(); tick(); tick();
    check("wrap_w1_data", bus.core_data_out, 32'hC03FC03E);
    check("wrap_w1_rptr", 32'(rptr), 32'h40);
    tick(); tick(); tick();
    check("wrap_w2_data", bus.core_data_out, 32'hC001C000);
    check("wrap_rptr", 32'(rptr), 32'h42);
    check("wrap_bit", 32'(rptr[6]), 32'd1);
    tick();
    check("wrap_nreads", 32'(rd_n - base), 32'd4);
    check("wrap_a0", 32'(rd_log[base]), 32'd62);
    check("wrap_a1", 32'(rd_log[base+1]), 32'd63);
    check("wrap_a2", 32'(rd_log[base+2]), 32'd0);
    check("wrap_a3", 32'(rd_log[base+3]), 32'd1);

    // Tokens: fresh reset, 6 words -> 3 pulses
    rst = 1'b1;
    wptr = 7'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    tok_base = tok_pulses;
    wptr = 7'd12;
    for (int i = 0; i < 24; i++) tick();
    check("tok_rptr", 32'(rptr), 32'd12);
    check("tok_pulses", 32'(tok_pulses - tok_base), 32'd3);
    check("tok_width", 32'(tok_long), 32'd0);
    check("tok_align", 32'(tok_misal), 32'd0);

    // Overrun: 64 is legal, 65 sets the sticky error
    bus.core_ready = 1'b0;
    wptr = 7'd76;
    tick();
    check("err_occ64", 32'(ptr_err), 32'd0);
    wptr = 7'd77;
    tick();
    check("err_set", 32'(ptr_err), 32'd1);
    tick(); tick();
    wptr = 7'd14;
    tick(); tick(); tick();
    check("err_occ_fixed", 32'(occupancy), 32'd0);
    check("err_sticky", 32'(ptr_err), 32'd1);
    rst = 1'b1;
    wptr = 7'd0;
    tick();
    rst = 1'b0;
    tick();
    check("err_cleared", 32'(ptr_err), 32'd0);
    check("err_rst_rptr", 32'(rptr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
